stage_4: RTL and testbench
==========================

Name: stage_4

Overview:
- Memory-access stage of the 5-stage RV32I pipeline; consumes the execute-stage outputs (alu_out, rs_2, rd_num, opcode, func_3, op_type).
- Memory ops (op_type=1): drives a request/acknowledge data-memory port with byte lanes, aligns load data, stalls upstream until the access retires.
- Non-memory ops: registered through to writeback in one cycle.

Parameters:
- ADDR_W, 32, width of dmem_addr; truncates i_alu_out[ADDR_W-1:0], low 2 bits cleared.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute-stage output valid
- i_alu_out  in  32  result or effective address
- i_rs_2  in  32  store data
- i_rd_num  in  5  destination register
- i_opcode  in  7  opcode (`LOAD/`STORE/`OP/...)
- i_func_3  in  3  width/sign code
- i_op_type  in  1  1 = memory op
- o_stall  out  1  upstream must hold inputs
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access done; rdata valid this cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle retire pulse
- wb_we  out  1  register-file write enable
- wb_rd_num  out  5  destination register
- wb_data  out  32  writeback value

Behaviour:
- Reset, async, rst_n=0: state IDLE; every output 0. Reset mid-access drops dmem_req at once; the pending access is discarded and no wb_valid follows.
- FSM states: IDLE, ACCESS. o_stall = (state==ACCESS), combinational.
- IDLE, i_valid=1, op_type=0:
  - next edge: wb_valid=1, wb_data=i_alu_out, wb_rd_num=i_rd_num.
  - wb_we=1 unless rd_num=0 or opcode is not one of OPIMM/OP/JAL/JALR/LUI/AUIPC.
  - Stay IDLE. Latency 1.
- IDLE, i_valid=1, op_type=1:
  - latch addr offset, func_3, rd_num, opcode.
  - next edge: state ACCESS, dmem_req=1, dmem_we=(opcode==`STORE), addr/be/wdata registered.
  - wb_valid=0.
- ACCESS: dmem_req and all dmem_* held stable until the cycle dmem_ack=1.
  - On that edge: dmem_req=0, state IDLE, wb_valid=1.
  - Loads: wb_we=(rd!=0), wb_data = aligned read data. Stores: wb_we=0, wb_data=0.
  - Minimum memory-op latency: accept N, req N+1, ack N+1, wb_valid N+2.
- dmem_ack is ignored in IDLE. wb_valid is 0 on every cycle not listed above.
- Lane rules, off = i_alu_out[1:0]:
  - SB: be=1<<off, wdata={4{rs_2[7:0]}}.
  - SH: be=3<<(off&2), wdata={2{rs_2[15:0]}}.
  - SW: be=4'hF.
  - Store func_3 3..7: be=0; request still issued.
- Load extract: word shifted right by 8*off (SH/LH/LHU use off&2).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW whole word.
  - func_3 3/6/7: wb_data=0.
- Misaligned addresses (without the option below): lanes are taken from the naturally aligned position as above; no error.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined: adds output o_misaligned (1 bit, reset 0). A memory op with misaligned off (LH/LHU/SH: off[0]=1; LW/SW: off!=0) issues no dmem_req and stays IDLE. Next edge: wb_valid=1, wb_we=0, o_misaligned=1 for one cycle.
- When undefined: port absent; alignment behaves as in Behaviour.

Decomposition:
- constants.vh gains LB/LH/LW/LBU/LHU/SB/SH/SW func_3 codes and state encodings; opcodes already live there.
- One combinational sub-module, mem_lane_align: computes be/wdata from (func_3, off, rs_2) and load data from (func_3, off, rdata). FSM and registers stay in stage_4.

Test Plan:
- OP add, alu_out=0x0000_0007, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_rd_num=5, wb_data=7, dmem_req never 1.
- SB, alu_out=0x103, rs_2=0xAABBCCDD, ack 1 cycle after req -> dmem_addr=0x100, be=4'b1000, wdata=0xDDDDDDDD, we=1; wb_we=0; o_stall high exactly 1 cycle.
- LB/LBU, addr 0x202, rdata=0x0080FF00, ack after 3 wait cycles -> dmem_req held 4 cycles; LB wb_data=0xFFFFFF80, LBU 0x00000080; o_stall high 4 cycles.
- LW to rd=0, rdata=0x12345678 -> wb_valid=1, wb_we=0.
- rst_n low while in ACCESS -> dmem_req=0 immediately; after release: no wb_valid, state IDLE, ack ignored.
- MISALIGN_TRAP_EN: LW at 0x102 -> no dmem_req, o_misaligned and wb_valid pulse 1 cycle, wb_we=0.

Source files
------------

// File: rtl/stage_4_pkg.sv
// stage_4_pkg: shared constants for the memory-access stage.
//   - RV32I opcodes used to decide register-file write enables
//   - load/store func_3 width codes
//   - FSM state encoding
//   - writes_rd(): true for non-memory opcodes that produce a register result
package stage_4_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_OPIMM) || (opc == OPC_OP)  || (opc == OPC_JAL) ||
           (opc == OPC_JALR)  || (opc == OPC_LUI) || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/stage_4_mem_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering.
//   st_*  : (is_store, func_3, off, rs_2) -> be_o, wdata_o for the request
//   ld_*  : (func_3, off, rdata)          -> ld_data_o, aligned and extended
// Halfword lanes always use off&2, so misaligned halves fall back to the
// naturally aligned halfword instead of straddling lanes.
module mem_lane_align
  import stage_4_pkg::*;
(
  input  logic        st_is_store_i,
  input  logic [2:0]  st_func3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_rs2_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] sh_b, sh_h;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    case (st_func3_i)
      F3_SB: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_rs2_i[7:0]}};
      end
      F3_SH: begin
        be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        wdata_o = {2{st_rs2_i[15:0]}};
      end
      F3_SW: begin
        be_o    = 4'b1111;
        wdata_o = st_rs2_i;
      end
      // Unsigned load widths share codes with illegal store widths; a store
      // with these codes still goes out, just with no lanes enabled.
      F3_LBU: if (!st_is_store_i) be_o = 4'b0001 << st_off_i;
      F3_LHU: if (!st_is_store_i) be_o = 4'b0011 << {st_off_i[1], 1'b0};
      default: ;
    endcase
  end

  assign sh_b = ld_rdata_i >> {ld_off_i, 3'b000};
  assign sh_h = ld_rdata_i >> {ld_off_i[1], 4'b0000};

  always_comb begin
    ld_data_o = 32'h0;
    case (ld_func3_i)
      F3_LB:   ld_data_o = {{24{sh_b[7]}}, sh_b[7:0]};
      F3_LH:   ld_data_o = {{16{sh_h[15]}}, sh_h[15:0]};
      F3_LW:   ld_data_o = ld_rdata_i;
      F3_LBU:  ld_data_o = {24'h0, sh_b[7:0]};
      F3_LHU:  ld_data_o = {16'h0, sh_h[15:0]};
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/stage_4.sv
// stage_4: memory-access stage of the RV32I pipeline.
//   Non-memory ops retire to writeback one cycle after acceptance.
//   Memory ops raise a request/acknowledge dmem access (IDLE -> ACCESS),
//   stall upstream while in ACCESS and retire on the dmem_ack edge.
// Ports: clk, rst_n (async low); i_* execute-stage inputs; o_stall;
//   dmem_* data-memory port; wb_* writeback outputs.
// Option MISALIGN_TRAP_EN: adds o_misaligned; misaligned LH/LHU/SH/LW/SW
//   skip the access and retire with wb_we=0 and a one-cycle o_misaligned.
module stage_4
  import stage_4_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [31:0]       i_alu_out,
  input  logic [31:0]       i_rs_2,
  input  logic [4:0]        i_rd_num,
  input  logic [6:0]        i_opcode,
  input  logic [2:0]        i_func_3,
  input  logic              i_op_type,
  output logic              o_stall,
`ifdef MISALIGN_TRAP_EN
  output logic              o_misaligned,
`endif
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd_num,
  output logic [31:0]       wb_data
);

  state_e            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              wbv_q, wbv_d, wbwe_q, wbwe_d;
  logic [4:0]        wbrd_q, wbrd_d;
  logic [31:0]       wbdata_q, wbdata_d;
  logic              mis_q, mis_d;

  logic              is_store, misaligned;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata, ld_data;

  assign is_store = (i_opcode == OPC_STORE);

`ifdef MISALIGN_TRAP_EN
  // Halfword (LH/LHU/SH) needs off[0]=0; word needs off=0.
  assign misaligned = i_op_type &&
      ((((i_func_3 == F3_LH) || (i_func_3 == F3_LHU && !is_store)) && i_alu_out[0]) ||
       ((i_func_3 == F3_LW) && (i_alu_out[1:0] != 2'b00)));
  assign o_misaligned = mis_q;
`else
  assign misaligned = 1'b0;
`endif

  mem_lane_align u_align (
    .st_is_store_i (is_store),
    .st_func3_i    (i_func_3),
    .st_off_i      (i_alu_out[1:0]),
    .st_rs2_i      (i_rs_2),
    .be_o          (st_be),
    .wdata_o       (st_wdata),
    .ld_func3_i    (f3_q),
    .ld_off_i      (off_q),
    .ld_rdata_i    (dmem_rdata),
    .ld_data_o     (ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_valid && i_op_type && !misaligned) state_d = S_ACCESS;
      S_ACCESS: if (dmem_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs / datapath next values
  always_comb begin
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    wbv_d    = 1'b0;
    wbwe_d   = 1'b0;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    mis_d    = 1'b0;
    case (state_q)
      S_IDLE: if (i_valid) begin
        if (!i_op_type) begin
          wbv_d    = 1'b1;
          wbwe_d   = (i_rd_num != 5'd0) && writes_rd(i_opcode);
          wbrd_d   = i_rd_num;
          wbdata_d = i_alu_out;
        end else if (misaligned) begin
          wbv_d    = 1'b1;
          wbrd_d   = i_rd_num;
          wbdata_d = 32'h0;
          mis_d    = 1'b1;
        end else begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {i_alu_out[ADDR_W-1:2], 2'b00};
          be_d    = st_be;
          wdata_d = st_wdata;
          f3_d    = i_func_3;
          off_d   = i_alu_out[1:0];
          rd_d    = i_rd_num;
        end
      end
      S_ACCESS: if (dmem_ack) begin
        req_d    = 1'b0;
        wbv_d    = 1'b1;
        wbrd_d   = rd_q;
        // we_q doubles as the latched "this is a store" flag
        wbwe_d   = !we_q && (rd_q != 5'd0);
        wbdata_d = we_q ? 32'h0 : ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      f3_q     <= 3'h0;
      off_q    <= 2'h0;
      rd_q     <= 5'h0;
      wbv_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      wbrd_q   <= 5'h0;
      wbdata_q <= 32'h0;
      mis_q    <= 1'b0;
    end else begin
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      wbv_q    <= wbv_d;
      wbwe_q   <= wbwe_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      mis_q    <= mis_d;
    end
  end

  assign o_stall    = (state_q == S_ACCESS);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wbv_q;
  assign wb_we      = wbwe_q;
  assign wb_rd_num  = wbrd_q;
  assign wb_data    = wbdata_q;

endmodule

// File: tb/tb_stage_4.sv
module tb_stage_4;
  import stage_4_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_valid = 1'b0, i_op_type = 1'b0;
  logic [31:0] i_alu_out = '0, i_rs_2 = '0;
  logic [4:0]  i_rd_num = '0;
  logic [6:0]  i_opcode = '0;
  logic [2:0]  i_func_3 = '0;
  logic        o_stall, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, wb_data;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd_num;
`ifdef MISALIGN_TRAP_EN
  logic        o_misaligned;
`endif

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  stage_4 #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_alu_out(i_alu_out),
    .i_rs_2(i_rs_2), .i_rd_num(i_rd_num), .i_opcode(i_opcode),
    .i_func_3(i_func_3), .i_op_type(i_op_type), .o_stall(o_stall),
`ifdef MISALIGN_TRAP_EN
    .o_misaligned(o_misaligned),
`endif
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd_num(wb_rd_num), .wb_data(wb_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one memory op and acks it after `waits` idle cycles in ACCESS.
  // Returns what the DUT showed at the first ACCESS cycle and at retirement.
  task automatic mem_op(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input int waits, output int req_cyc, output int stall_cyc,
                        output logic [31:0] a, output logic [3:0] be,
                        output logic [31:0] wd, output logic we,
                        output logic wbv, output logic wbwe, output logic [31:0] wbd);
    i_valid = 1'b1; i_op_type = 1'b1; i_opcode = opc; i_func_3 = f3;
    i_alu_out = addr; i_rs_2 = rs2; i_rd_num = rd; dmem_rdata = rdata;
    tick;
    i_valid = 1'b0;
    a = dmem_addr; be = dmem_be; wd = dmem_wdata; we = dmem_we;
    req_cyc = 0; stall_cyc = 0;
    for (int k = 0; k <= waits; k++) begin
      if (dmem_req) req_cyc++;
      if (o_stall) stall_cyc++;
      dmem_ack = (k == waits);
      tick;
    end
    dmem_ack = 1'b0;
    wbv = wb_valid; wbwe = wb_we; wbd = wb_data;
  endtask

  task automatic test_reset;
    #12;
    n_tests++;
    if ({o_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_we, wb_rd_num, wb_data} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs req=%b stall=%b wbv=%b", dmem_req, o_stall, wb_valid);
    end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_nonmem;
    i_valid = 1; i_op_type = 0; i_opcode = OPC_OP; i_alu_out = 32'h7; i_rd_num = 5'd5;
    tick;
    i_valid = 0;
    n_tests++;
    if ({wb_valid, wb_we, wb_rd_num, wb_data, dmem_req} !== {1'b1, 1'b1, 5'd5, 32'h7, 1'b0}) begin
      n_fail++; $display("FAIL op_add: got v=%b we=%b rd=%0d d=%h req=%b want 1 1 5 7 0", wb_valid, wb_we, wb_rd_num, wb_data, dmem_req);
    end
    tick;
    n_tests++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL op_add_pulse: wb_valid=%b want 0", wb_valid); end
    i_valid = 1; i_opcode = OPC_OPIMM; i_alu_out = 32'h55; i_rd_num = 5'd0;
    tick;
    n_tests++;
    if ({wb_valid, wb_we} !== 2'b10) begin n_fail++; $display("FAIL op_rd0: v=%b we=%b want 1 0", wb_valid, wb_we); end
    i_opcode = OPC_BRANCH; i_rd_num = 5'd3;
    tick;
    i_valid = 0;
    n_tests++;
    if ({wb_valid, wb_we} !== 2'b10) begin n_fail++; $display("FAIL op_branch: v=%b we=%b want 1 0", wb_valid, wb_we); end
    tick;
  endtask

  task automatic test_back_to_back;
    i_valid = 1; i_op_type = 0; i_opcode = OPC_LUI; i_alu_out = 32'hABCD_0000; i_rd_num = 5'd9;
    tick;
    i_opcode = OPC_JAL; i_alu_out = 32'h0000_0104; i_rd_num = 5'd1;
    n_tests++;
    if ({wb_valid, wb_we, wb_rd_num, wb_data} !== {2'b11, 5'd9, 32'hABCD_0000}) begin
      n_fail++; $display("FAIL b2b_first: v=%b we=%b rd=%0d d=%h", wb_valid, wb_we, wb_rd_num, wb_data);
    end
    tick;
    i_valid = 0;
    n_tests++;
    if ({wb_valid, wb_we, wb_rd_num, wb_data} !== {2'b11, 5'd1, 32'h0000_0104}) begin
      n_fail++; $display("FAIL b2b_second: v=%b we=%b rd=%0d d=%h", wb_valid, wb_we, wb_rd_num, wb_data);
    end
    tick;
  endtask

  task automatic test_stores;
    int rc, sc; logic [31:0] a, wd, wbd; logic [3:0] be; logic we, wbv, wbwe;
    mem_op(OPC_STORE, F3_SB, 32'h103, 32'hAABBCCDD, 5'd4, 32'h0, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({a, be, wd, we} !== {32'h100, 4'b1000, 32'hDDDDDDDD, 1'b1}) begin
      n_fail++; $display("FAIL sb_req: addr=%h be=%b wd=%h we=%b want 100 1000 DDDDDDDD 1", a, be, wd, we);
    end
    n_tests++;
    if ({wbv, wbwe, wbd, sc, rc} !== {1'b1, 1'b0, 32'h0, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL sb_wb: wbv=%b we=%b d=%h stall=%0d req=%0d want 1 0 0 1 1", wbv, wbwe, wbd, sc, rc);
    end
    n_tests++;
    if ({dmem_req, o_stall} !== 2'b00) begin n_fail++; $display("FAIL sb_done: req=%b stall=%b want 0 0", dmem_req, o_stall); end
    tick;
    mem_op(OPC_STORE, F3_SH, 32'h102, 32'h1234ABCD, 5'd4, 32'h0, 1, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({a, be, wd} !== {32'h100, 4'b1100, 32'hABCDABCD}) begin
      n_fail++; $display("FAIL sh_req: addr=%h be=%b wd=%h want 100 1100 ABCDABCD", a, be, wd);
    end
    mem_op(OPC_STORE, F3_SW, 32'h208, 32'hCAFEF00D, 5'd4, 32'h0, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({a, be, wd} !== {32'h208, 4'b1111, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL sw_req: addr=%h be=%b wd=%h want 208 1111 CAFEF00D", a, be, wd);
    end
    mem_op(OPC_STORE, 3'd3, 32'h300, 32'h1, 5'd4, 32'h0, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({rc, be, wbv} !== {32'd1, 4'b0000, 1'b1}) begin
      n_fail++; $display("FAIL st_f3_3: req_cycles=%0d be=%b wbv=%b want 1 0000 1", rc, be, wbv);
    end
    tick;
  endtask

  task automatic test_loads;
    int rc, sc; logic [31:0] a, wd, wbd; logic [3:0] be; logic we, wbv, wbwe;
    mem_op(OPC_LOAD, F3_LB, 32'h202, 32'h0, 5'd7, 32'h0080FF00, 3, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({a, we, rc, sc} !== {32'h200, 1'b0, 32'd4, 32'd4}) begin
      n_fail++; $display("FAIL lb_req: addr=%h we=%b req=%0d stall=%0d want 200 0 4 4", a, we, rc, sc);
    end
    n_tests++;
    if ({wbv, wbwe, wb_rd_num, wbd} !== {2'b11, 5'd7, 32'hFFFFFF80}) begin
      n_fail++; $display("FAIL lb_data: v=%b we=%b rd=%0d d=%h want 1 1 7 FFFFFF80", wbv, wbwe, wb_rd_num, wbd);
    end
    mem_op(OPC_LOAD, F3_LBU, 32'h202, 32'h0, 5'd7, 32'h0080FF00, 3, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({wbv, wbd, rc} !== {1'b1, 32'h00000080, 32'd4}) begin
      n_fail++; $display("FAIL lbu_data: v=%b d=%h req=%0d want 1 00000080 4", wbv, wbd, rc);
    end
    mem_op(OPC_LOAD, F3_LW, 32'h100, 32'h0, 5'd0, 32'h12345678, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({wbv, wbwe, wbd} !== {2'b10, 32'h12345678}) begin
      n_fail++; $display("FAIL lw_rd0: v=%b we=%b d=%h want 1 0 12345678", wbv, wbwe, wbd);
    end
    mem_op(OPC_LOAD, F3_LHU, 32'h202, 32'h0, 5'd2, 32'h80011234, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({wbwe, wbd} !== {1'b1, 32'h00008001}) begin
      n_fail++; $display("FAIL lhu_data: we=%b d=%h want 1 00008001", wbwe, wbd);
    end
    mem_op(OPC_LOAD, 3'd6, 32'h200, 32'h0, 5'd2, 32'hFFFFFFFF, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({wbv, wbd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ld_f3_6: v=%b d=%h want 1 0", wbv, wbd); end
    tick;
    n_tests++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_pulse: wb_valid=%b want 0", wb_valid); end
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
    i_valid = 1; i_op_type = 1; i_opcode = OPC_LOAD; i_func_3 = F3_LW; i_alu_out = 32'h102; i_rd_num = 5'd6;
    tick;
    i_valid = 0;
    n_tests++;
    if ({dmem_req, o_stall, wb_valid, wb_we, o_misaligned} !== 5'b00101) begin
      n_fail++; $display("FAIL trap_lw: req=%b stall=%b v=%b we=%b mis=%b want 0 0 1 0 1", dmem_req, o_stall, wb_valid, wb_we, o_misaligned);
    end
    tick;
    n_tests++;
    if ({dmem_req, wb_valid, o_misaligned} !== 3'b000) begin
      n_fail++; $display("FAIL trap_pulse: req=%b v=%b mis=%b want 0 0 0", dmem_req, wb_valid, o_misaligned);
    end
`else
    int rc, sc; logic [31:0] a, wd, wbd; logic [3:0] be; logic we, wbv, wbwe;
    mem_op(OPC_LOAD, F3_LH, 32'h203, 32'h0, 5'd3, 32'h80010000, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({a, wbd} !== {32'h200, 32'hFFFF8001}) begin
      n_fail++; $display("FAIL lh_misal: addr=%h d=%h want 200 FFFF8001", a, wbd);
    end
    mem_op(OPC_LOAD, F3_LW, 32'h102, 32'h0, 5'd3, 32'h12345678, 0, rc, sc, a, be, wd, we, wbv, wbwe, wbd);
    n_tests++;
    if ({a, be, wbd} !== {32'h100, 4'b1111, 32'h12345678}) begin
      n_fail++; $display("FAIL lw_misal: addr=%h be=%b d=%h want 100 1111 12345678", a, be, wbd);
    end
`endif
    tick;
  endtask

  task automatic test_reset_mid_access;
    i_valid = 1; i_op_type = 1; i_opcode = OPC_LOAD; i_func_3 = F3_LW; i_alu_out = 32'h400; i_rd_num = 5'd8;
    tick;
    i_valid = 0;
    n_tests++;
    if ({dmem_req, o_stall} !== 2'b11) begin n_fail++; $display("FAIL rst_pre: req=%b stall=%b want 1 1", dmem_req, o_stall); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({dmem_req, o_stall, wb_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_async: req=%b stall=%b v=%b want 0 0 0", dmem_req, o_stall, wb_valid);
    end
    tick;
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_tests++;
      if ({dmem_req, o_stall, wb_valid} !== 3'b000) begin
        n_fail++; $display("FAIL rst_after_%0d: req=%b stall=%b v=%b want 0 0 0", k, dmem_req, o_stall, wb_valid);
      end
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset;
    test_nonmem;
    test_back_to_back;
    test_stores;
    test_loads;
    test_misalign;
    test_reset_mid_access;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
